// File: rtl/io_input_debouncer.sv
// Debounces the scanned per-board input bytes one byte per clock after each sample tick and
// queues a change event (index, new value, changed bits) into a small FIFO.
module io_input_debouncer #(
  parameter int unsigned BOARDS           = 16,
  parameter int unsigned INSTALLED_BOARDS = 2,
  parameter int unsigned DEBOUNCE_COUNT   = 3,
  parameter int unsigned CNT_W            = 4,
  parameter int unsigned FIFO_DEPTH       = 8,
  localparam int unsigned RW              = (BOARDS > 1) ? $clog2(BOARDS) : 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [BOARDS*8-1:0] regs_in_i,
  input  logic              sample_tick_i,
  output logic              busy_o,
  output logic [BOARDS*8-1:0] stable_o,
  output logic              event_valid_o,
  input  logic              event_ready_i,
  output logic [RW-1:0]     event_reg_o,
  output logic [7:0]        event_value_o,
  output logic [7:0]        event_mask_o,
  output logic              overflow_o,
  input  logic              clear_overflow_i
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  typedef struct packed {
    logic [RW-1:0] idx;
    logic [7:0]    value;
    logic [7:0]    mask;
  } event_t;

  state_e        state_q, state_d;
  logic [RW-1:0] idx_q, idx_d;

  logic [7:0]       stable_q [BOARDS];
  logic [7:0]       stable_d [BOARDS];
  logic [7:0]       cand_q   [BOARDS];
  logic [7:0]       cand_d   [BOARDS];
  logic [CNT_W-1:0] cnt_q    [BOARDS];
  logic [CNT_W-1:0] cnt_d    [BOARDS];

  logic   [7:0] raw;
  logic         push;
  event_t       push_ev;

  event_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, pop, do_push, drop;
  event_t        head;

  // FSM: state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (sample_tick_i) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        if (idx_q == RW'(INSTALLED_BOARDS - 1)) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == StScan);
  end

  // Per-byte debounce for the byte currently addressed by idx_q
  always_comb begin
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_ev  = '0;
    raw      = regs_in_i[{idx_q, 3'b000} +: 8];
    if (state_q == StScan) begin
      if (raw != cand_q[idx_q]) begin
        cand_d[idx_q] = raw;
        cnt_d[idx_q]  = '0;
      end else if (cand_q[idx_q] != stable_q[idx_q]) begin
        if (cnt_q[idx_q] == CNT_W'(DEBOUNCE_COUNT - 1)) begin
          stable_d[idx_q] = cand_q[idx_q];
          cnt_d[idx_q]    = '0;
          push            = 1'b1;
          push_ev.idx     = idx_q;
          push_ev.value   = cand_q[idx_q];
          push_ev.mask    = cand_q[idx_q] ^ stable_q[idx_q];
        end else begin
          cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
        end
      end else begin
        cnt_d[idx_q] = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < BOARDS; r++) begin
        stable_q[r] <= '0;
        cand_q[r]   <= '0;
        cnt_q[r]    <= '0;
      end
    end else begin
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
    end
  end

  // Bytes outside the installed range are never scanned and read as zero
  always_comb begin
    stable_o = '0;
    for (int r = 0; r < BOARDS; r++) begin
      if (r < INSTALLED_BOARDS) begin
        stable_o[r*8 +: 8] = stable_q[r];
      end
    end
  end

  // Event FIFO
  assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop     = event_valid_o & event_ready_i;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (do_push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: head outputs are forced to zero while empty
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_ev;
  end

  assign head          = mem_q[rd_ptr_q];
  assign event_valid_o = (count_q != '0);
  assign event_reg_o   = event_valid_o ? head.idx   : '0;
  assign event_value_o = event_valid_o ? head.value : '0;
  assign event_mask_o  = event_valid_o ? head.mask  : '0;
  assign overflow_o    = overflow_q;

endmodule

// File: doc/io_input_debouncer.md
Name: io_input_debouncer

Overview:
- Consumes the raw per-board input register bytes gathered by the IO register scanner (regs_in, BOARDS×8 bits).
- Produces debounced, stable copies of those bytes and a FIFO of change events for the emulator core (keyboard, switches, panel buttons).
- Scans one register byte per clock after each sample tick, applies a per-byte consecutive-match debounce, and queues an event whenever a byte's stable value changes.

Parameters:
- BOARDS, 16, number of register bytes on the regs_in bus; index width RW = $clog2(BOARDS).
- INSTALLED_BOARDS, 2, number of bytes actually scanned (indices 0..INSTALLED_BOARDS-1); the rest are ignored and hold 0.
- DEBOUNCE_COUNT, 3, consecutive matching scans required to commit a change (≥1).
- CNT_W, 4, width of each per-byte debounce counter; must hold DEBOUNCE_COUNT.
- FIFO_DEPTH, 8, event FIFO entries (power of 2).

Ports:
- Clk  input  1  clock.
- Rst_n  input  1  reset, asynchronous, active-low.
- regs_in_i  input  BOARDS*8  raw input bytes from the scanner; byte r = bits [8r+7:8r].
- sample_tick_i  input  1  one-cycle pulse that starts a scan pass.
- busy_o  output  1  high while a scan pass is in progress.
- stable_o  output  BOARDS*8  debounced byte values.
- event_valid_o  output  1  FIFO head valid.
- event_ready_i  input  1  consumer accepts the head when valid and ready are both high.
- event_reg_o  output  RW  register index of the head event.
- event_value_o  output  8  new stable value of the head event.
- event_mask_o  output  8  bits that changed (new XOR old).
- overflow_o  output  1  sticky: an event was dropped.
- clear_overflow_i  input  1  synchronous clear of overflow_o.

Behaviour:
- Reset: all stable, candidate and counter state is 0; FIFO is empty; busy_o=0, event_valid_o=0, overflow_o=0; event_reg/value/mask_o=0; FSM in IDLE.
- FSM IDLE: when sample_tick_i=1, set idx to 0 and go to SCAN (busy_o=1 from the next cycle).
- FSM SCAN: process byte idx each cycle.
  - If idx = INSTALLED_BOARDS-1, go to IDLE; otherwise idx+1.
  - A pass takes exactly INSTALLED_BOARDS cycles.
  - sample_tick_i while in SCAN is ignored; it is not queued.
- Per-byte processing, with raw = regs_in_i byte idx sampled in that cycle:
  - raw ≠ candidate: candidate←raw, cnt←0.
  - raw = candidate ≠ stable, cnt = DEBOUNCE_COUNT-1: stable←candidate, cnt←0, push event {idx, candidate, candidate^stable}.
  - raw = candidate ≠ stable, otherwise: cnt←cnt+1.
  - raw = candidate = stable: cnt←0.
  - Net effect: a new value is committed on the (DEBOUNCE_COUNT+1)-th consecutive pass that observes it.
  - stable_o for that byte updates on the commit clock edge.
- Event FIFO:
  - Registered; a pushed event is visible on the head outputs the cycle after the push edge.
  - Pop occurs on a clock edge where event_valid_o and event_ready_i are both high.
  - Head outputs are held stable while valid=1 and ready=0.
  - Push when full with no pop: the event is dropped, overflow_o←1, and stable is still committed.
  - Push and pop in the same cycle when full: both succeed and the count is unchanged.
  - Push into an empty FIFO with ready=1: the event still appears the next cycle.
  - At most one push per cycle; events are ordered by ascending idx within a pass, and passes are ordered in time.
- overflow_o: clear_overflow_i clears it unless an overflow occurs in the same cycle; set wins.
- Reset asserted mid-scan or mid-FIFO: everything returns immediately to the reset values, and pending events are lost.
- Bytes with index ≥ INSTALLED_BOARDS are never scanned and their stable_o stays 0.

Test Plan:
- Reset, then regs_in byte0=0x00 with 5 ticks → no events; stable_o=0; busy_o high for exactly 2 cycles per tick (INSTALLED_BOARDS=2).
- Byte0 changes to 0x05 and holds, DEBOUNCE_COUNT=3 → after the 4th tick: event {reg 0, value 0x05, mask 0x05}; stable_o[7:0]=0x05 on that pass's commit edge.
- Bounce: byte0 goes 0x05,0x00,0x05,0x05,0x05,0x05 across ticks → exactly one event, committed on the 6th pass; no event for 0x00.
- Byte0→0x01 and byte1→0x80 in the same pass, held → two events in order: {0,0x01,0x01}, then {1,0x80,0x80}.
- FIFO_DEPTH=4, ready=0, drive 5 commits → 4 events retained, overflow_o=1; clear_overflow_i → 0; draining yields the first 4 events in order.
- Reset asserted mid-pass with 2 events queued → event_valid_o=0, stable_o=0, busy_o=0 immediately; the next tick starts a pass at idx 0.
